dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (dmem).
- Requester 0 is the core load/store path. Requester 1 is the debug/VIO path.
- One access is in flight at a time. Round-robin fairness applies when both request.
- Drives the dmem address, byte-write-enable and write-data inputs, and returns dmem read data to the winning requester with a one-cycle valid pulse.

Parameters:
- DMEM_WIDTH, default `dmem_width (32): data width of dmem and of each requester's data ports.
- DMEM_ADDR, default `dmem_addr: address width.
- NBYTE, default DMEM_WIDTH/8 (4): byte-enable width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_req  in  1  requester 0 access request; held until r0_gnt.
- r0_we  in  NBYTE  byte write enables; all zero means read.
- r0_addr  in  DMEM_ADDR  word address.
- r0_wdata  in  DMEM_WIDTH  write data.
- r0_lock  in  1  lock request (used only with DMEM_ARB_LOCK_EN).
- r0_gnt  out  1  one-cycle pulse: request accepted.
- r0_rvalid  out  1  one-cycle pulse: access complete; r0_rdata valid.
- r0_rdata  out  DMEM_WIDTH  read data.
- r1_req, r1_we, r1_addr, r1_wdata, r1_lock, r1_gnt, r1_rvalid, r1_rdata: same as r0_*, for requester 1.
- dmem_daddr  out  DMEM_ADDR  to dmem daddr.
- dmem_we  out  NBYTE  to dmem we.
- dmem_indata  out  DMEM_WIDTH  to dmem indata.
- dmem_outdata  in  DMEM_WIDTH  from dmem outdata; synchronous read, valid the cycle after the address is presented.

Behaviour:
- Reset values: state=IDLE; rr_last=1 (requester 0 wins first); every gnt, rvalid, dmem_we, dmem_daddr, dmem_indata and rdata is 0.
- Reset is asynchronous: dmem_we drops to 0 the moment rst_n falls, which aborts any in-flight write.
- All outputs are registered.
- FSM states are IDLE, ISSUE and CAPTURE.
- IDLE: at the edge, the arbiter samples r0_req and r1_req.
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both request: grant the requester that is not rr_last.
  - On a grant: register the winner's addr/we/wdata onto the dmem_* outputs, pulse gnt_winner, record winner, go to ISSUE.
- ISSUE: dmem performs the access at this edge. Next state is CAPTURE, and dmem_we is cleared to 0.
- CAPTURE: at the edge:
  - For a read (registered we==0), capture dmem_outdata into rdata_winner.
  - For a write, rdata_winner is unchanged.
  - Pulse rvalid_winner for one cycle, set rr_last=winner, go to IDLE.
- Latency, with E0 as the sampling edge:
  - gnt is high in the cycle after E0.
  - dmem_we is high for exactly that same one cycle.
  - rvalid is high in the cycle after E2.
  - Peak throughput is one access per 3 cycles.
- A requester must hold req/addr/we/wdata stable until gnt. Req asserted again after gnt is treated as a new request.
- Req changes while in ISSUE or CAPTURE are ignored. Requests are sampled only in IDLE.
- rdata holds its last value between rvalid pulses.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - If the winner's lock input is high at grant, the winner becomes lock owner.
  - While the owner's lock stays high, IDLE grants only the owner; the other requester waits with no gnt.
  - The lock is released in IDLE when the owner's lock is low.
  - This supports atomic read-modify-write.
- Without the macro: r0_lock and r1_lock are ignored and the ports remain for a stable interface. Pure round-robin.

Decomposition:
- `dmem_width, `dmem_addr and the FSM state encodings (IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2) go in parameters.v.
- The round-robin winner select is a natural sub-module, rr_pick2 (combinational): inputs req0, req1, last, lock_valid, lock_owner; outputs winner, any.
- The top-level debug wrapper instantiates dmem_arbiter between the requesters and dmem.

Test Plan:
- Write, then read:
  - r0 write addr=5, we=4'hF, wdata=32'hDEADBEEF → r0_gnt in cycle 1, dmem_we=4'hF for one cycle, r0_rvalid in cycle 3.
  - r0 read addr=5 → r0_rdata=32'hDEADBEEF with r0_rvalid.
- Byte enable: over the word above, r1 write we=4'b0010, wdata=32'h0000AA00; then read → 32'hDEADAAEF.
- Contention: r0_req and r1_req both held for 4 accesses after reset → grants r0,r1,r0,r1; gnt pulses 3 cycles apart; never two gnt in the same cycle.
- Reset mid-write: rst_n low during ISSUE of a write to addr 7 holding 32'h1 → dmem_we=0 immediately; all outputs 0 after reset; addr 7 still reads 32'h1 or the new value, with no partial-byte corruption of other addresses.
- Lock (with DMEM_ARB_LOCK_EN): r0_lock=1 across read addr=3 then write addr=3, with r1_req held → both r0 accesses complete before r1_gnt; without the macro → r1 is granted between them.
- Idle hold: no requests for 10 cycles → gnt, rvalid and dmem_we stay 0; rdata retains its last value.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths and FSM encoding for the dmem arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DmemWidth = 32;
  localparam int unsigned DmemAddr  = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin winner select with optional lock override.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic lock_valid_i,
  input  logic lock_owner_i,
  output logic winner_o,
  output logic any_o
);

  // A held lock restricts the pick to its owner; otherwise alternate on conflict.
  always_comb begin
    winner_o = 1'b0;
    any_o    = 1'b0;
    if (lock_valid_i) begin
      winner_o = lock_owner_i;
      any_o    = lock_owner_i ? req1_i : req0_i;
    end else begin
      any_o    = req0_i | req1_i;
      winner_o = (req0_i && req1_i) ? ~last_i : req1_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port dmem.
// Optional lock support for atomic RMW is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DMEM_WIDTH = DmemWidth,
  parameter int unsigned DMEM_ADDR  = DmemAddr,
  parameter int unsigned NBYTE      = DMEM_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req_i,
  input  logic [NBYTE-1:0]      r0_we_i,
  input  logic [DMEM_ADDR-1:0]  r0_addr_i,
  input  logic [DMEM_WIDTH-1:0] r0_wdata_i,
  input  logic                  r0_lock_i,
  output logic                  r0_gnt_o,
  output logic                  r0_rvalid_o,
  output logic [DMEM_WIDTH-1:0] r0_rdata_o,
  input  logic                  r1_req_i,
  input  logic [NBYTE-1:0]      r1_we_i,
  input  logic [DMEM_ADDR-1:0]  r1_addr_i,
  input  logic [DMEM_WIDTH-1:0] r1_wdata_i,
  input  logic                  r1_lock_i,
  output logic                  r1_gnt_o,
  output logic                  r1_rvalid_o,
  output logic [DMEM_WIDTH-1:0] r1_rdata_o,
  output logic [DMEM_ADDR-1:0]  dmem_daddr_o,
  output logic [NBYTE-1:0]      dmem_we_o,
  output logic [DMEM_WIDTH-1:0] dmem_indata_o,
  input  logic [DMEM_WIDTH-1:0] dmem_outdata_i
);

  arb_state_e state_q;
  logic       rr_last_q;
  logic       winner_q;
  logic       rd_q;
  logic       pick_winner;
  logic       pick_any;
  logic       lock_active;
  logic       lock_owner;
  logic       winner_lock;

  assign winner_lock = pick_winner ? r1_lock_i : r0_lock_i;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_valid_q;
  logic lock_owner_q;
  assign lock_owner  = lock_owner_q;
  // Lock only binds while its owner keeps lock asserted.
  assign lock_active = lock_valid_q & (lock_owner_q ? r1_lock_i : r0_lock_i);

  // Lock ownership: taken at grant, dropped in IDLE once the owner lets go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (!lock_active) lock_valid_q <= 1'b0;
      if (pick_any && winner_lock) begin
        lock_valid_q <= 1'b1;
        lock_owner_q <= pick_winner;
      end
    end
  end
`else
  logic unused_lock;
  assign lock_active = 1'b0;
  assign lock_owner  = 1'b0;
  assign unused_lock = winner_lock;
`endif

  rr_pick2 u_pick (
    .req0_i       (r0_req_i),
    .req1_i       (r1_req_i),
    .last_i       (rr_last_q),
    .lock_valid_i (lock_active),
    .lock_owner_i (lock_owner),
    .winner_o     (pick_winner),
    .any_o        (pick_any)
  );

  // Access sequencer: IDLE grants and drives dmem, ISSUE ends the write, CAPTURE returns data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_last_q     <= 1'b1;
      winner_q      <= 1'b0;
      rd_q          <= 1'b0;
      r0_gnt_o      <= 1'b0;
      r1_gnt_o      <= 1'b0;
      r0_rvalid_o   <= 1'b0;
      r1_rvalid_o   <= 1'b0;
      r0_rdata_o    <= '0;
      r1_rdata_o    <= '0;
      dmem_daddr_o  <= '0;
      dmem_we_o     <= '0;
      dmem_indata_o <= '0;
    end else begin
      r0_gnt_o    <= 1'b0;
      r1_gnt_o    <= 1'b0;
      r0_rvalid_o <= 1'b0;
      r1_rvalid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            winner_q      <= pick_winner;
            dmem_daddr_o  <= pick_winner ? r1_addr_i : r0_addr_i;
            dmem_we_o     <= pick_winner ? r1_we_i : r0_we_i;
            dmem_indata_o <= pick_winner ? r1_wdata_i : r0_wdata_i;
            rd_q          <= pick_winner ? ~|r1_we_i : ~|r0_we_i;
            r0_gnt_o      <= ~pick_winner;
            r1_gnt_o      <= pick_winner;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          dmem_we_o <= '0;
          state_q   <= StCapture;
        end
        StCapture: begin
          if (rd_q) begin
            if (winner_q) r1_rdata_o <= dmem_outdata_i;
            else          r0_rdata_o <= dmem_outdata_i;
          end
          r0_rvalid_o <= ~winner_q;
          r1_rvalid_o <= winner_q;
          rr_last_q   <= winner_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural dmem.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned W  = DmemWidth;
  localparam int unsigned A  = DmemAddr;
  localparam int unsigned NB = W / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_req, r1_req, r0_lock, r1_lock;
  logic [NB-1:0] r0_we, r1_we;
  logic [A-1:0]  r0_addr, r1_addr;
  logic [W-1:0]  r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [W-1:0]  r0_rdata, r1_rdata;
  logic [A-1:0]  dmem_daddr;
  logic [NB-1:0] dmem_we;
  logic [W-1:0]  dmem_indata, dmem_outdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r0_req_i       (r0_req),
    .r0_we_i        (r0_we),
    .r0_addr_i      (r0_addr),
    .r0_wdata_i     (r0_wdata),
    .r0_lock_i      (r0_lock),
    .r0_gnt_o       (r0_gnt),
    .r0_rvalid_o    (r0_rvalid),
    .r0_rdata_o     (r0_rdata),
    .r1_req_i       (r1_req),
    .r1_we_i        (r1_we),
    .r1_addr_i      (r1_addr),
    .r1_wdata_i     (r1_wdata),
    .r1_lock_i      (r1_lock),
    .r1_gnt_o       (r1_gnt),
    .r1_rvalid_o    (r1_rvalid),
    .r1_rdata_o     (r1_rdata),
    .dmem_daddr_o   (dmem_daddr),
    .dmem_we_o      (dmem_we),
    .dmem_indata_o  (dmem_indata),
    .dmem_outdata_i (dmem_outdata)
  );

  // Synchronous single-port memory with byte writes.
  logic [W-1:0] mem [0:(1<<A)-1];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (dmem_we[b]) mem[dmem_daddr][8*b +: 8] <= dmem_indata[8*b +: 8];
    end
    dmem_outdata <= mem[dmem_daddr];
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit id, input logic [A-1:0] addr, input logic [NB-1:0] we,
                       input logic [W-1:0] wdata);
    if (id) begin
      r1_req = 1'b1; r1_addr = addr; r1_we = we; r1_wdata = wdata;
    end else begin
      r0_req = 1'b1; r0_addr = addr; r0_we = we; r0_wdata = wdata;
    end
  endtask

  // One complete access; returns at the negedge where rvalid is high.
  task automatic access(input bit id, input logic [A-1:0] addr, input logic [NB-1:0] we,
                        input logic [W-1:0] wdata, output logic [W-1:0] rdata);
    int n;
    @(negedge clk);
    drive(id, addr, we, wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!(id ? r1_gnt : r0_gnt) && n < 20);
    check("gnt_wait", W'(n < 20), W'(1));
    if (id) r1_req = 1'b0; else r0_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(id ? r1_rvalid : r0_rvalid) && n < 10);
    check("rvalid_wait", W'(n), W'(2));
    rdata = id ? r1_rdata : r0_rdata;
  endtask

  initial begin
    logic [W-1:0] rd;
    int           cyc, last_cyc, ng, r0_phase;
    logic [2:0]   order;
    logic [2:0]   exp_order;

    r0_req = 0; r1_req = 0; r0_lock = 0; r1_lock = 0;
    r0_we = '0; r1_we = '0; r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", W'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, dmem_we}), '0);
    check("rst_daddr", W'(dmem_daddr), '0);
    check("rst_indata", dmem_indata, '0);
    check("rst_rdata", r0_rdata | r1_rdata, '0);
    rst_n = 1'b1;

    // Contention: both held, expect r0,r1,r0,r1 three cycles apart.
    @(negedge clk);
    drive(0, 8'd1, '0, '0);
    drive(1, 8'd2, '0, '0);
    cyc = 0; last_cyc = 0; ng = 0;
    while (ng < 4 && cyc < 30) begin
      @(negedge clk); cyc++;
      check("dual_gnt", W'(r0_gnt & r1_gnt), '0);
      if (r0_gnt || r1_gnt) begin
        if (ng > 0) check("gnt_spacing", W'(cyc - last_cyc), W'(3));
        check("rr_order", W'(r1_gnt), W'(ng % 2));
        last_cyc = cyc;
        ng++;
      end
    end
    check("contention_grants", W'(ng), W'(4));
    r0_req = 0; r1_req = 0;
    repeat (4) @(negedge clk);

    // Write with latency checks.
    drive(0, 8'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_gnt", W'({r0_gnt, r1_gnt}), W'(2'b10));
    check("wr_we", W'(dmem_we), W'(4'hF));
    check("wr_addr", W'(dmem_daddr), W'(5));
    check("wr_data", dmem_indata, 32'hDEADBEEF);
    r0_req = 0;
    @(negedge clk);
    check("wr_c2", W'({r0_gnt, r0_rvalid, dmem_we}), '0);
    @(negedge clk);
    check("wr_rvalid", W'(r0_rvalid), W'(1));
    @(negedge clk);
    check("wr_rvalid_pulse", W'(r0_rvalid), '0);

    access(0, 8'd5, '0, '0, rd);
    check("rd_5", rd, 32'hDEADBEEF);

    // Byte enable merge from requester 1.
    access(1, 8'd5, 4'b0010, 32'h0000AA00, rd);
    access(1, 8'd5, '0, '0, rd);
    check("byte_merge", rd, 32'hDEADAAEF);

    // Idle hold.
    repeat (10) begin
      @(negedge clk);
      check("idle_quiet", W'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, dmem_we}), '0);
    end
    check("idle_r0_rdata", r0_rdata, 32'hDEADBEEF);
    check("idle_r1_rdata", r1_rdata, 32'hDEADAAEF);

    // Lock: r0 read then write addr 3 with lock held, r1 contending.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rst2_rdata", r0_rdata | r1_rdata, '0);
    @(negedge clk);
    drive(0, 8'd3, '0, '0);
    r0_lock = 1'b1;
    drive(1, 8'd9, 4'hF, 32'h12345678);
    ng = 0; r0_phase = 0; cyc = 0; order = '0;
    while (ng < 3 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (r0_gnt) begin
        r0_req = 1'b0; order[ng] = 1'b0; ng++;
        if (r0_phase == 1) r0_lock = 1'b0;
      end
      if (r1_gnt && ng < 3) begin
        r1_req = 1'b0; order[ng] = 1'b1; ng++;
      end
      if (r0_rvalid && r0_phase == 0) begin
        r0_phase = 1;
        drive(0, 8'd3, 4'hF, 32'hCAFEF00D);
      end
    end
`ifdef DMEM_ARB_LOCK_EN
    exp_order = 3'b100;
`else
    exp_order = 3'b010;
`endif
    check("lock_order", W'(order), W'(exp_order));
    r0_req = 0; r1_req = 0; r0_lock = 0;
    repeat (6) @(negedge clk);
    access(0, 8'd3, '0, '0, rd);
    check("lock_rd3", rd, 32'hCAFEF00D);
    access(1, 8'd9, '0, '0, rd);
    check("lock_rd9", rd, 32'h12345678);

    // Reset during ISSUE of a write must abort it.
    access(0, 8'd7, 4'hF, 32'h1, rd);
    @(negedge clk);
    drive(0, 8'd7, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    check("mid_we_before", W'(dmem_we), W'(4'hF));
    r0_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_we_async", W'(dmem_we), '0);
    check("mid_outs", W'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, dmem_daddr}), '0);
    check("mid_data", dmem_indata | r0_rdata | r1_rdata, '0);
    @(negedge clk); rst_n = 1'b1;
    access(0, 8'd7, '0, '0, rd);
    check("mid_rd7", rd, 32'h1);
    access(1, 8'd5, '0, '0, rd);
    check("mid_rd5", rd, 32'hDEADAAEF);
    access(0, 8'd9, '0, '0, rd);
    check("mid_rd9", rd, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
